serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial unsigned/two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
//  Counterpart to the accumulator's adder datapath; built around a half-subtractor cell.
//  Used where area matters more than latency; start/done handshake toward the controlling FSM.
// PARAMETERS
//  WIDTH  8  operand and result width in bits (>= 2)
// PORTS
//  clk    in   1      single clock, all state updates on rising edge
//  rst_n  in   1      reset, asynchronous, active-low
//  start  in   1      request; sampled on rising edge while not busy
//  a      in   WIDTH  minuend, captured on accepted start
//  b      in   WIDTH  subtrahend, captured on accepted start
//  busy   out  1      high while bits are being processed (state SHIFT)
//  done   out  1      one-cycle pulse: diff/bout/ovf valid
//  diff   out  WIDTH  result a - b modulo 2^WIDTH, held until next accepted start completes
//  bout   out  1      final borrow (1 iff a < b unsigned)
//  ovf    out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; shift regs,
//   borrow FF, bit counter cleared. Reset mid-operation aborts; no done pulse follows.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE : start=1 -> load a,b into shift regs, borrow FF=0, count=0 -> SHIFT.
//   SHIFT: each edge: d = a0^b0^brw; brw' = (~a0&b0) | (~(a0^b0)&brw); shift d into
//          result reg MSB end, shift a,b right; count++. When count==WIDTH-1 -> DONE,
//          commit diff, bout=brw', ovf computed from captured MSBs and new diff MSB.
//   DONE : done=1 for exactly this cycle; start=1 here accepted as in IDLE (back-to-back).
//          Otherwise -> IDLE.
//  Latency: start sampled at edge E0; done high in the cycle after edge E_WIDTH.
//   Throughput: one operation per WIDTH+1 cycles back-to-back.
//  start while busy (SHIFT): ignored; a/b changes during SHIFT have no effect.
//  diff/bout/ovf change only on the commit edge; stable otherwise, incl. during next SHIFT.
//  Width rules: counter is $clog2(WIDTH) bits; no wrap beyond WIDTH-1.
//  Equal operands -> diff=0, bout=0, ovf=0. Borrow out of MSB discarded from diff.
// STRUCTURE
//  Shared header serial_sub_defs.vh: state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
//  Sub-module half_subtractor(in1,in2,diff,bout): diff=in1^in2, bout=~in1&in2.
//   Full-subtract bit cell = two half_subtractor instances + OR of borrows.
//  Top holds FSM, counter, operand/result shift regs, borrow FF.
// TESTING (WIDTH=8)
//  a=8'h5A,b=8'h23,start 1 cycle -> busy 8 cycles, done at E8: diff=8'h37,bout=0,ovf=0
//  a=8'h10,b=8'h20 -> diff=8'hF0,bout=1,ovf=0
//  a=8'h80,b=8'h01 -> diff=8'h7F,bout=0,ovf=1; a=8'h7F,b=8'hFF -> diff=8'h80,bout=1,ovf=1
//  start again at E3 of a running op with a=8'hFF -> ignored; original result, one done pulse
//  rst_n low at E4 of op -> all outputs 0 immediately, no done; fresh start works normally
//  start held high through DONE -> second op accepted, done pulses 9 cycles apart

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the signed-overflow rule.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Signed overflow of a - b: operands of opposite sign and a result whose
  // sign differs from the minuend.
  function automatic logic subOverflow(input logic aMsb,
                                       input logic bMsb,
                                       input logic diffMsb);
    return (aMsb != bMsb) && (diffMsb != aMsb);
  endfunction

endpackage

// File: rtl/serial_subtractor_half_sub.sv
// Half-subtractor cell: difference and borrow of in1 - in2 for one bit.
// Two of these plus an OR on the borrows form the full-subtract bit cell.
module half_subtractor (
  input  logic in1_i,
  input  logic in2_i,
  output logic diff_o,
  output logic bout_o
);

  // Borrow is needed only when subtracting 1 from 0.
  always_comb begin
    diff_o = in1_i ^ in2_i;
    bout_o = ~in1_i & in2_i;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// Holds the control FSM, bit counter, operand/result shift registers and the
// borrow flip-flop. Results are held until the next operation commits.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             ovf_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             partDiff, partBorrow;
  logic             bitDiff, carryBorrow;
  logic             bitBorrow;

  // First cell subtracts the operand bits, second cell subtracts the
  // incoming borrow from that partial difference.
  half_subtractor uOperandCell (
    .in1_i  (aSh_q[0]),
    .in2_i  (bSh_q[0]),
    .diff_o (partDiff),
    .bout_o (partBorrow)
  );

  half_subtractor uBorrowCell (
    .in1_i  (partDiff),
    .in2_i  (brw_q),
    .diff_o (bitDiff),
    .bout_o (carryBorrow)
  );

  // Either stage producing a borrow means the bit as a whole borrows.
  always_comb begin
    bitBorrow = partBorrow | carryBorrow;
  end

  // Next-state logic: load on an accepted start, shift one bit per cycle,
  // commit the visible result on the last bit.
  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    aMsb_d  = aMsb_q;
    bMsb_d  = bMsb_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          aSh_d   = a_i;
          bSh_d   = b_i;
          aMsb_d  = a_i[WIDTH-1];
          bMsb_d  = b_i[WIDTH-1];
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        aSh_d = aSh_q >> 1;
        bSh_d = bSh_q >> 1;
        res_d = {bitDiff, res_q[WIDTH-1:1]};
        brw_d = bitBorrow;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          diff_d  = {bitDiff, res_q[WIDTH-1:1]};
          bout_d  = bitBorrow;
          ovf_d   = subOverflow(aMsb_q, bMsb_q, bitDiff);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      aMsb_q  <= aMsb_d;
      bMsb_q  <= bMsb_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status and result outputs are decoded straight from registers.
  always_comb begin
    busy_o = (state_q == S_SHIFT);
    done_o = (state_q == S_DONE);
    diff_o = diff_q;
    bout_o = bout_q;
    ovf_o  = ovf_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8). Expected results
// are queued when an operation is driven and compared when done pulses.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] diff_o;
  logic         bout_o;
  logic         ovf_o;

  exp_t         sb[$];
  int           assertCount = 0;
  int           failCount   = 0;
  int           doneCount   = 0;
  int           cyc         = 0;
  logic [W-1:0] heldDiff    = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .diff_o  (diff_o),
    .bout_o  (bout_o),
    .ovf_o   (ovf_o)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure spacing between done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain arithmetic on whole words.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.diff = a - b;
    e.bout = (a < b);
    e.ovf  = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
    return e;
  endfunction

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      doneCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("diff", 32'(diff_o), 32'(e.diff));
        checkOutput("bout", 32'(bout_o), 32'(e.bout));
        checkOutput("ovf",  32'(ovf_o),  32'(e.ovf));
        heldDiff = e.diff;
      end
    end
  end

  // Drive one operation, optionally re-pulsing start with a=FF after
  // injectAt busy cycles, and check busy length, result hold and done count.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int injectAt);
    int busyCnt;
    int doneBefore;
    bit seen;
    busyCnt    = 0;
    seen       = 0;
    @(negedge clk);
    doneBefore = doneCount;
    a_i        = a;
    b_i        = b;
    start_i    = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start_i    = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done_o) begin
        seen = 1;
      end else begin
        if (busy_o) begin
          busyCnt++;
          checkOutput("diff held during shift", 32'(diff_o), 32'(heldDiff));
        end
        if (busyCnt == injectAt) begin
          start_i = 1'b1;
          a_i     = 8'hFF;
        end else begin
          start_i = 1'b0;
          a_i     = W'($urandom);
        end
        b_i = W'($urandom);
        @(negedge clk);
      end
    end
    start_i = 1'b0;
    checkOutput("done seen", 32'(seen), 32'd1);
    checkOutput("busy cycles", 32'(busyCnt), 32'(W));
    repeat (3) @(negedge clk);
    checkOutput("single done pulse", 32'(doneCount - doneBefore), 32'd1);
  endtask

  // Bounded wait for a done pulse at negedge; returns the cycle it was seen.
  task automatic waitDone(output int when);
    bit seen;
    seen = 0;
    when = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1;
        when = cyc;
      end
    end
    checkOutput("done before timeout", 32'(seen), 32'd1);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t1, t2;
    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    checkOutput("reset done", 32'(done_o), 32'd0);
    checkOutput("reset diff", 32'(diff_o), 32'd0);
    checkOutput("reset bout", 32'(bout_o), 32'd0);
    checkOutput("reset ovf",  32'(ovf_o),  32'd0);
    rst_n = 1'b1;

    applyStimulus(8'h5A, 8'h23, -1);
    applyStimulus(8'h10, 8'h20, -1);
    applyStimulus(8'h80, 8'h01, -1);
    applyStimulus(8'h3C, 8'h3C, -1);
    applyStimulus(8'h00, 8'hFF, -1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(W'($urandom), W'($urandom), -1);
    end

    // Start request in the middle of a running operation must be ignored.
    applyStimulus(8'h44, 8'h11, 3);
    applyStimulus(8'h7F, 8'hFF, -1);

    // Reset part-way through an operation: outputs clear, no done follows.
    @(negedge clk);
    a_i     = 8'h5A;
    b_i     = 8'h23;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy_o), 32'd0);
    checkOutput("abort done", 32'(done_o), 32'd0);
    checkOutput("abort diff", 32'(diff_o), 32'd0);
    checkOutput("abort bout", 32'(bout_o), 32'd0);
    checkOutput("abort ovf",  32'(ovf_o),  32'd0);
    heldDiff = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    applyStimulus(8'hC3, 8'h5E, -1);

    // Start held high through DONE: second operation follows immediately.
    @(negedge clk);
    a_i     = 8'h21;
    b_i     = 8'h42;
    start_i = 1'b1;
    sb.push_back(model(8'h21, 8'h42));
    @(negedge clk);
    a_i     = 8'h90;
    b_i     = 8'h15;
    sb.push_back(model(8'h90, 8'h15));
    waitDone(t1);
    @(negedge clk);
    start_i = 1'b0;
    waitDone(t2);
    checkOutput("back-to-back spacing", 32'(t2 - t1), 32'(W + 1));
    repeat (4) @(negedge clk);

    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
